// File: rtl/tgl_pkg.sv
// tgl_pkg: shared constants, types and helpers for the toggle handshake receiver
package tgl_pkg;

    localparam int TGL_SYNC_DEFAULT = 2;

    typedef logic [15:0] tgl_total_t;

    function automatic int tgl_max(int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/tgl_sync.sv
// tgl_sync: multi-flop synchroniser chain for one asynchronous input bit
module tgl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // shift the raw input through the chain, cleared to 0 by reset
    always_ff @(posedge clk or posedge reset)
        if (reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};

    assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_handshake_responder.sv
// toggle_handshake_responder: toggle-event receiver with pending counter and ack toggle; optional evt_total via TGL_RX_EVT_TOTAL_EN
module toggle_handshake_responder
    import tgl_pkg::*;
#(
    parameter int SYNC_STAGES = TGL_SYNC_DEFAULT,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_tgl,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             ack_tgl,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    input  logic             ovf_clr
`ifdef TGL_RX_EVT_TOTAL_EN
    ,
    output logic [15:0]      evt_total
`endif
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(tgl_max(CNT_W));

    logic sync_out, req_prev;
    logic evt_in, accept, grow, shrink, drop;

    tgl_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (req_tgl),
        .q     (sync_out)
    );

    assign evt_valid = pending != '0;
    assign evt_in    = sync_out ^ req_prev;
    assign accept    = evt_valid && evt_ready;
    assign grow      = evt_in && !accept;
    assign shrink    = accept && !evt_in;
    assign drop      = grow && pending == MAX;

    // edge history, pending count, sticky overflow and the returned ack toggle
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            req_prev <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
            ack_tgl  <= 1'b0;
        end else begin
            req_prev <= sync_out;
            if (grow && !drop) pending <= pending + 1'b1;
            else if (shrink)   pending <= pending - 1'b1;
            overflow <= drop || (overflow && !ovf_clr);
            if (accept) ack_tgl <= ~ack_tgl;
        end

`ifdef TGL_RX_EVT_TOTAL_EN
    // free-running count of every detected edge, dropped ones included
    always_ff @(posedge clk or posedge reset)
        if (reset)       evt_total <= '0;
        else if (evt_in) evt_total <= evt_total + 16'd1;
`endif

endmodule

// File: tb/tb_toggle_handshake_responder.sv
// tb_toggle_handshake_responder: table, directed and random checks against an event-arrival model
module tb_toggle_handshake_responder;

    logic       clk = 0, reset = 1, req_tgl = 0, evt_ready = 0, ovf_clr = 0;
    logic       evt_valid, ack_tgl, overflow;
    logic [3:0] pending;
`ifdef TGL_RX_EVT_TOTAL_EN
    logic [15:0] evt_total;
`endif

    toggle_handshake_responder #(.SYNC_STAGES(2), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_tgl   (req_tgl),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .ack_tgl   (ack_tgl),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
`ifdef TGL_RX_EVT_TOTAL_EN
        ,
        .evt_total (evt_total)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // reference model: a level change first sampled at edge k is counted at edge k+2
    int   edge_n;
    logic prev_req;
    int   arrivals[$];
    int   m_pend, m_total;
    logic m_ovf, m_ack;

    typedef struct {
        logic       req, rdy, clr;
        logic [3:0] pend;
        logic       v, ack, ovf;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        edge_n = 0; prev_req = 0; arrivals.delete();
        m_pend = 0; m_total = 0; m_ovf = 0; m_ack = 0;
    endtask

    task automatic step(input logic r, input logic rdy, input logic clr);
        logic ein, acc, drop;
        req_tgl = r; evt_ready = rdy; ovf_clr = clr;
        edge_n++;
        if (r != prev_req) arrivals.push_back(edge_n + 2);
        prev_req = r;
        ein = arrivals.size() > 0 && arrivals[0] == edge_n;
        if (ein) void'(arrivals.pop_front());
        acc  = m_pend > 0 && rdy;
        drop = ein && !acc && m_pend == 15;
        if (ein) m_total = (m_total + 1) % 65536;
        if (ein && !acc && !drop) m_pend++;
        else if (acc && !ein)     m_pend--;
        m_ovf = drop || (m_ovf && !clr);
        if (acc) m_ack = ~m_ack;
        @(posedge clk); #1;
        chk("pending", 32'(pending), 32'(m_pend));
        chk("evt_valid", 32'(evt_valid), 32'(m_pend != 0));
        chk("ack_tgl", 32'(ack_tgl), 32'(m_ack));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef TGL_RX_EVT_TOTAL_EN
        chk("evt_total", 32'(evt_total), 32'(m_total));
`endif
    endtask

    task automatic do_reset();
        reset = 1; req_tgl = 0; evt_ready = 0; ovf_clr = 0;
        model_reset();
        #1;
        chk("rst_pending", 32'(pending), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_ack", 32'(ack_tgl), 0);
        chk("rst_ovf", 32'(overflow), 0);
        @(posedge clk); #1;
        reset = 0;
    endtask

    logic r;

    initial begin
        for (int i = 0; i < 9; i++) tbl[i] = '{i >= 4, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};

        // single event, consumer always ready
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].rdy, tbl[i].clr);
            chk("tbl_pend", 32'(pending), 32'(tbl[i].pend));
            chk("tbl_valid", 32'(evt_valid), 32'(tbl[i].v));
            chk("tbl_ack", 32'(ack_tgl), 32'(tbl[i].ack));
            chk("tbl_ovf", 32'(overflow), 32'(tbl[i].ovf));
        end

        // five spaced toggles queued, then drained one per cycle
        do_reset(); r = 0;
        for (int i = 0; i < 5; i++) begin
            r = ~r; step(r, 0, 0);
            for (int j = 0; j < 3; j++) step(r, 0, 0);
        end
        chk("t2_pend5", 32'(pending), 5);
        for (int i = 0; i < 5; i++) step(r, 1, 0);
        chk("t2_drained", 32'(pending), 0);
        chk("t2_ack_end", 32'(ack_tgl), 1);

        // saturation and overflow clear
        do_reset(); r = 0;
        for (int i = 0; i < 16; i++) begin r = ~r; step(r, 0, 0); end
        for (int i = 0; i < 3; i++) step(r, 0, 0);
        chk("t3_pend15", 32'(pending), 15);
        chk("t3_ovf", 32'(overflow), 1);
        step(r, 0, 1);
        chk("t3_ovf_clr", 32'(overflow), 0);
        chk("t3_pend_hold", 32'(pending), 15);

        // accept and arrival together at saturation
        r = ~r; step(r, 0, 0);
        step(r, 0, 0);
        step(r, 1, 0);
        chk("t4_pend15", 32'(pending), 15);
        chk("t4_no_ovf", 32'(overflow), 0);
        step(r, 0, 0);

        // asynchronous reset mid-stream
        do_reset(); r = 0;
        for (int i = 0; i < 3; i++) begin r = ~r; step(r, 0, 0); end
        for (int i = 0; i < 3; i++) step(r, 0, 0);
        chk("t5_pend3", 32'(pending), 3);
        #2; reset = 1; req_tgl = 0; model_reset(); #1;
        chk("t5_async_pend", 32'(pending), 0);
        chk("t5_async_valid", 32'(evt_valid), 0);
        chk("t5_async_ack", 32'(ack_tgl), 0);
        @(posedge clk); #1; reset = 0;
        for (int i = 0; i < 6; i++) step(0, 1, 0);
        chk("t5_no_ack", 32'(ack_tgl), 0);

`ifdef TGL_RX_EVT_TOTAL_EN
        // total counter keeps counting dropped events
        do_reset(); r = 0;
        for (int i = 0; i < 20; i++) begin r = ~r; step(r, 0, 0); end
        for (int i = 0; i < 3; i++) step(r, 0, 0);
        chk("t6_total", 32'(evt_total), 20);
        chk("t6_pend", 32'(pending), 15);
        chk("t6_ovf", 32'(overflow), 1);
`endif

        // random traffic against the model
        do_reset(); r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0) r = ~r;
            step(r, $urandom_range(3) == 0, $urandom_range(15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
